rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_pkg.sv | 35 +++
 rtl/rr_mux_arbiter_mux.sv | 15 +
 rtl/rr_mux_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin 8:1 mux arbiter: state encoding, sizes, search helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rr_mux_arbiter_pkg;

  localparam int ARB_NUM_REQ = 8;
  localparam int ARB_SEL_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [ARB_SEL_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above start, wrapping past the top index.
  function automatic rr_pick_t rr_pick(input logic [ARB_NUM_REQ-1:0] req,
                                       input logic [ARB_SEL_W-1:0]   start);
    rr_pick_t             res;
    logic [ARB_SEL_W-1:0] cand;
    res = '0;
    for (int k = 0; k < ARB_NUM_REQ; k++) begin
      cand = start + ARB_SEL_W'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Plain 8:1 single-bit multiplexer.
// Latency: combinational.
// Backpressure: none.
module mux_8_1 (
  input  logic [7:0] data_in,
  input  logic [2:0] sel,
  output logic       data_out
);

  // Pick the selected data bit.
  always_comb begin
    data_out = data_in[sel];
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning an 8:1 mux; optional grant-hold timeout under ARB_TIMEOUT_EN.
// Latency: grant/select/valid one edge after req; data_out combinational from registered select.
// Backpressure: owner keeps the mux while its req is high (bounded by MAX_HOLD when ARB_TIMEOUT_EN).
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int SEL_W    = ARB_SEL_W,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               valid,
  output logic               data_out
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  // The search helper and the mux are built for exactly eight requesters.
  if (NUM_REQ != ARB_NUM_REQ || SEL_W != ARB_SEL_W || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_mux_arbiter: NUM_REQ must be 8, SEL_W 3, MAX_HOLD >= 1");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic               valid_q, valid_d;
  rr_pick_t           pick;
  logic               release_own;
  logic               take;
  logic               mux_dat;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
  logic               expire;
`endif

  // Next-state: pick the round-robin winner among requesters other than the current owner.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    select_d    = select_q;
    last_d      = last_q;
    valid_d     = valid_q;
    // Excluding the owner lets the same search serve idle, release and forced handoff.
    pick        = rr_pick(req & ~grant_q, last_q + SEL_W'(1));
    release_own = (state_q == ST_GRANT) && !req[select_q];
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    expire      = (state_q == ST_GRANT) && req[select_q] &&
                  (hold_cnt_q >= HOLD_W'(MAX_HOLD));
    take        = pick.found && ((state_q == ST_IDLE) || release_own || expire);
`else
    take        = pick.found && ((state_q == ST_IDLE) || release_own);
`endif
    if (take) begin
      state_d  = ST_GRANT;
      grant_d  = NUM_REQ'(1) << pick.idx;
      select_d = pick.idx;
      last_d   = pick.idx;
      valid_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = HOLD_W'(1);
      timeout_d  = expire;
`endif
    end else if (release_own) begin
      // Nobody else waiting: go idle, keep select so the bus index stays stable.
      state_d = ST_IDLE;
      grant_d = '0;
      valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end
`ifdef ARB_TIMEOUT_EN
    else if (state_q == ST_GRANT) begin
      // Limit reached with no contender: restart the count and keep the grant.
      hold_cnt_d = expire ? HOLD_W'(1) : hold_cnt_q + HOLD_W'(1);
    end
`endif
  end

  // State and registered outputs; last starts at 7 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      last_q   <= SEL_W'(NUM_REQ - 1);
      valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  mux_8_1 u_mux (
    .data_in  (data_in),
    .sel      (select_q),
    .data_out (mux_dat)
  );

  assign grant    = grant_q;
  assign select   = select_q;
  assign valid    = valid_q;
  assign data_out = valid_q & mux_dat;
`ifdef ARB_TIMEOUT_EN
  assign timeout  = timeout_q;
`endif

endmodule
